// File: rtl/mem_block_dispatcher.sv
// mem_block_dispatcher
// Takes a completed refill block from the memory controller, writes it into
// the cache data/tag array, then hands the critical word to user readout
// over a valid/ready handshake and signals completion to the control unit.
// Optional build macro: DISPATCH_PERF_CNT_EN adds a saturating 16-bit count
// of completed dispatches on o_dispatch_count.
module mem_block_dispatcher #(
  parameter int ADDR_WIDTH      = 16,
  parameter int INDEX_WIDTH     = 6,
  parameter int TAG_WIDTH       = 10,
  parameter int WORD_WIDTH      = 40,
  parameter int WORDS_PER_BLOCK = 8
) (
  input  logic                                  clk,
  input  logic                                  arst,
  input  logic                                  i_halt,
  input  logic [WORD_WIDTH*WORDS_PER_BLOCK-1:0] i_mem_block_data,
  input  logic                                  i_mem_block_data_valid,
  input  logic [ADDR_WIDTH-1:0]                 i_block_addr,
  input  logic                                  i_block_addr_valid,
  input  logic [2:0]                            i_req_word_offset,
  input  logic                                  i_user_ready,
  output logic                                  o_arr_wr_en,
  output logic [INDEX_WIDTH-1:0]                o_arr_wr_index,
  output logic [TAG_WIDTH-1:0]                  o_arr_wr_tag,
  output logic [WORD_WIDTH*WORDS_PER_BLOCK-1:0] o_arr_wr_data,
  output logic [WORD_WIDTH-1:0]                 o_user_data,
  output logic                                  o_user_data_valid,
  output logic                                  o_dispatch_done,
`ifdef DISPATCH_PERF_CNT_EN
  output logic [15:0]                           o_dispatch_count,
`endif
  output logic                                  o_dispatch_err
);

  localparam int BLOCK_WIDTH = WORD_WIDTH * WORDS_PER_BLOCK;

  typedef enum logic [2:0] {
    IDLE,
    WRITE,
    READOUT,
    DONE,
    ERR
  } state_t;

  state_t                  state;
  logic                    r_valid_d;
  logic                    rise;
  logic [2:0]              offset;
  logic [WORD_WIDTH-1:0]   word_sel;
  logic                    wr_q;
  logic                    done_q;
  logic                    err_q;
  logic                    user_valid_q;
  logic [WORD_WIDTH-1:0]   user_data_q;
  logic [INDEX_WIDTH-1:0]  index_q;
  logic [TAG_WIDTH-1:0]    tag_q;
  logic [BLOCK_WIDTH-1:0]  data_q;

  assign rise = i_mem_block_data_valid & ~r_valid_d;

  // Critical word mux over the captured block
  always_comb begin
    word_sel = '0;
    case (offset)
      3'd0: word_sel = data_q[WORD_WIDTH*0 +: WORD_WIDTH];
      3'd1: word_sel = data_q[WORD_WIDTH*1 +: WORD_WIDTH];
      3'd2: word_sel = data_q[WORD_WIDTH*2 +: WORD_WIDTH];
      3'd3: word_sel = data_q[WORD_WIDTH*3 +: WORD_WIDTH];
      3'd4: word_sel = data_q[WORD_WIDTH*4 +: WORD_WIDTH];
      3'd5: word_sel = data_q[WORD_WIDTH*5 +: WORD_WIDTH];
      3'd6: word_sel = data_q[WORD_WIDTH*6 +: WORD_WIDTH];
      3'd7: word_sel = data_q[WORD_WIDTH*7 +: WORD_WIDTH];
      default: word_sel = '0;
    endcase
  end

  // Dispatch sequencer with capture registers and registered outputs.
  // Strobe flags are registered per state and gated by halt at the output,
  // so a halted WRITE/DONE/ERR cycle emits nothing yet still fires once.
  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      state        <= IDLE;
      r_valid_d    <= 1'b1;
      offset       <= '0;
      index_q      <= '0;
      tag_q        <= '0;
      data_q       <= '0;
      wr_q         <= 1'b0;
      done_q       <= 1'b0;
      err_q        <= 1'b0;
      user_valid_q <= 1'b0;
      user_data_q  <= '0;
    end else if (!i_halt) begin
      r_valid_d <= i_mem_block_data_valid;
      wr_q      <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
      case (state)
        IDLE: begin
          if (rise) begin
            if (i_block_addr_valid) begin
              index_q <= i_block_addr[INDEX_WIDTH-1:0];
              tag_q   <= i_block_addr[ADDR_WIDTH-1:INDEX_WIDTH];
              data_q  <= i_mem_block_data;
              offset  <= i_req_word_offset;
              wr_q    <= 1'b1;
              state   <= WRITE;
            end else begin
              err_q <= 1'b1;
              state <= ERR;
            end
          end
        end
        WRITE: begin
          user_data_q  <= word_sel;
          user_valid_q <= 1'b1;
          state        <= READOUT;
        end
        READOUT: begin
          if (i_user_ready) begin
            user_valid_q <= 1'b0;
            done_q       <= 1'b1;
            state        <= DONE;
          end
        end
        DONE:    state <= IDLE;
        ERR:     state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

`ifdef DISPATCH_PERF_CNT_EN
  // Saturating count of completed (unhalted DONE) dispatches
  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      o_dispatch_count <= '0;
    end else if (!i_halt && state == DONE && o_dispatch_count != 16'hFFFF) begin
      o_dispatch_count <= o_dispatch_count + 16'd1;
    end
  end
`endif

  assign o_arr_wr_en       = wr_q & ~i_halt;
  assign o_dispatch_done   = done_q & ~i_halt;
  assign o_dispatch_err    = err_q & ~i_halt;
  assign o_arr_wr_index    = index_q;
  assign o_arr_wr_tag      = tag_q;
  assign o_arr_wr_data     = data_q;
  assign o_user_data       = user_data_q;
  assign o_user_data_valid = user_valid_q;

endmodule

// File: tb/tb_mem_block_dispatcher.sv
// Directed self-checking bench for mem_block_dispatcher.
// Build with +define+DISPATCH_PERF_CNT_EN to also check the dispatch counter.
module tb_mem_block_dispatcher;

  logic         clk = 1'b0;
  logic         arst;
  logic         i_halt;
  logic [319:0] i_mem_block_data;
  logic         i_mem_block_data_valid;
  logic [15:0]  i_block_addr;
  logic         i_block_addr_valid;
  logic [2:0]   i_req_word_offset;
  logic         i_user_ready;
  logic         o_arr_wr_en;
  logic [5:0]   o_arr_wr_index;
  logic [9:0]   o_arr_wr_tag;
  logic [319:0] o_arr_wr_data;
  logic [39:0]  o_user_data;
  logic         o_user_data_valid;
  logic         o_dispatch_done;
  logic         o_dispatch_err;
`ifdef DISPATCH_PERF_CNT_EN
  logic [15:0]  o_dispatch_count;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mem_block_dispatcher #(
    .ADDR_WIDTH(16),
    .INDEX_WIDTH(6),
    .TAG_WIDTH(10),
    .WORD_WIDTH(40),
    .WORDS_PER_BLOCK(8)
  ) dut (
    .clk(clk),
    .arst(arst),
    .i_halt(i_halt),
    .i_mem_block_data(i_mem_block_data),
    .i_mem_block_data_valid(i_mem_block_data_valid),
    .i_block_addr(i_block_addr),
    .i_block_addr_valid(i_block_addr_valid),
    .i_req_word_offset(i_req_word_offset),
    .i_user_ready(i_user_ready),
    .o_arr_wr_en(o_arr_wr_en),
    .o_arr_wr_index(o_arr_wr_index),
    .o_arr_wr_tag(o_arr_wr_tag),
    .o_arr_wr_data(o_arr_wr_data),
    .o_user_data(o_user_data),
    .o_user_data_valid(o_user_data_valid),
    .o_dispatch_done(o_dispatch_done),
`ifdef DISPATCH_PERF_CNT_EN
    .o_dispatch_count(o_dispatch_count),
`endif
    .o_dispatch_err(o_dispatch_err)
  );

  task automatic chk(input string tag, input logic [319:0] obs, input logic [319:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance one clock; inputs are driven and outputs sampled 2 time units after the edge
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  logic [319:0] blk;

  initial begin
    blk = '0;
    for (int k = 0; k < 8; k++) blk[k*40 +: 40] = {8'hC0 + 8'(k), 32'hDEAD_0000 + 32'(k)};
    blk[3*40 +: 40] = 40'h12_3456_789A;

    arst = 1'b1;
    i_halt = 1'b0;
    i_mem_block_data = blk;
    i_mem_block_data_valid = 1'b1;
    i_block_addr = 16'h1234;
    i_block_addr_valid = 1'b1;
    i_req_word_offset = 3'd0;
    i_user_ready = 1'b0;

    // Reset state
    tick();
    tick();
    chk("rst_wr_en", o_arr_wr_en, 0);
    chk("rst_index", o_arr_wr_index, 0);
    chk("rst_tag", o_arr_wr_tag, 0);
    chk("rst_data", o_arr_wr_data, 0);
    chk("rst_user_valid", o_user_data_valid, 0);
    chk("rst_user_data", o_user_data, 0);
    chk("rst_done", o_dispatch_done, 0);
    chk("rst_err", o_dispatch_err, 0);
`ifdef DISPATCH_PERF_CNT_EN
    chk("rst_count", o_dispatch_count, 0);
`endif

    // Release reset with valid already high: must not dispatch
    arst = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("relhigh_wr_en", o_arr_wr_en, 0);
      chk("relhigh_err", o_dispatch_err, 0);
      chk("relhigh_user_valid", o_user_data_valid, 0);
    end

    // Basic dispatch: addr ABC5, offset 3, ready high
    i_mem_block_data_valid = 1'b0;
    tick();
    i_block_addr = 16'hABC5;
    i_req_word_offset = 3'd3;
    i_user_ready = 1'b1;
    i_mem_block_data_valid = 1'b1;
    tick();
    chk("t2_wr_en", o_arr_wr_en, 1);
    chk("t2_index", o_arr_wr_index, 6'h05);
    chk("t2_tag", o_arr_wr_tag, 10'h2AF);
    chk("t2_data", o_arr_wr_data, blk);
    chk("t2_uv_early", o_user_data_valid, 0);
    tick();
    chk("t2_wr_en_off", o_arr_wr_en, 0);
    chk("t2_user_valid", o_user_data_valid, 1);
    chk("t2_user_data", o_user_data, 40'h12_3456_789A);
    chk("t2_done_early", o_dispatch_done, 0);
    tick();
    chk("t2_done", o_dispatch_done, 1);
    chk("t2_uv_after", o_user_data_valid, 0);
    tick();
    chk("t2_done_once", o_dispatch_done, 0);
    tick();
    chk("t2_done_once2", o_dispatch_done, 0);
    chk("t2_no_rewrite", o_arr_wr_en, 0);

    // Backpressure: ready low for 5 cycles, offset 6, addr 0042
    i_mem_block_data_valid = 1'b0;
    tick();
    i_user_ready = 1'b0;
    i_block_addr = 16'h0042;
    i_req_word_offset = 3'd6;
    i_mem_block_data_valid = 1'b1;
    tick();
    chk("t3_wr_en", o_arr_wr_en, 1);
    chk("t3_index", o_arr_wr_index, 6'h02);
    chk("t3_tag", o_arr_wr_tag, 10'h001);
    tick();
    for (int i = 0; i < 5; i++) begin
      chk("t3_hold_valid", o_user_data_valid, 1);
      chk("t3_hold_data", o_user_data, 40'hC6_DEAD_0006);
      chk("t3_hold_done", o_dispatch_done, 0);
      tick();
    end
    i_user_ready = 1'b1;
    chk("t3_valid_at_ready", o_user_data_valid, 1);
    tick();
    chk("t3_done", o_dispatch_done, 1);
    tick();
    chk("t3_done_once", o_dispatch_done, 0);

    // Block arrives with invalid address
    i_mem_block_data_valid = 1'b0;
    tick();
    i_block_addr_valid = 1'b0;
    i_mem_block_data_valid = 1'b1;
    tick();
    chk("t4_err", o_dispatch_err, 1);
    chk("t4_wr_en", o_arr_wr_en, 0);
    chk("t4_user_valid", o_user_data_valid, 0);
    tick();
    chk("t4_err_once", o_dispatch_err, 0);
    chk("t4_user_valid2", o_user_data_valid, 0);
    chk("t4_wr_en2", o_arr_wr_en, 0);

    // Halt for 3 cycles while in WRITE
    i_mem_block_data_valid = 1'b0;
    tick();
    i_block_addr_valid = 1'b1;
    i_block_addr = 16'h1F80;
    i_req_word_offset = 3'd0;
    i_mem_block_data_valid = 1'b1;
    tick();
    i_halt = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("t5_halt_wr_en", o_arr_wr_en, 0);
      chk("t5_halt_uv", o_user_data_valid, 0);
      tick();
    end
    i_halt = 1'b0;
    #1;
    chk("t5_wr_en", o_arr_wr_en, 1);
    chk("t5_index", o_arr_wr_index, 6'h00);
    chk("t5_tag", o_arr_wr_tag, 10'h07E);
    tick();
    chk("t5_no_dup", o_arr_wr_en, 0);
    chk("t5_user_valid", o_user_data_valid, 1);
    chk("t5_user_data", o_user_data, 40'hC0_DEAD_0000);
    tick();
    chk("t5_done", o_dispatch_done, 1);
    tick();
    chk("t5_done_once", o_dispatch_done, 0);
`ifdef DISPATCH_PERF_CNT_EN
    chk("count3", o_dispatch_count, 16'd3);
`endif

    // Asynchronous reset during READOUT
    i_mem_block_data_valid = 1'b0;
    tick();
    i_user_ready = 1'b0;
    i_block_addr = 16'hABC5;
    i_req_word_offset = 3'd3;
    i_mem_block_data_valid = 1'b1;
    tick();
    tick();
    chk("t6_pre_valid", o_user_data_valid, 1);
    arst = 1'b1;
    #1;
    chk("t6_rst_uv", o_user_data_valid, 0);
    chk("t6_rst_ud", o_user_data, 0);
    chk("t6_rst_index", o_arr_wr_index, 0);
    chk("t6_rst_tag", o_arr_wr_tag, 0);
    chk("t6_rst_data", o_arr_wr_data, 0);
    chk("t6_rst_done", o_dispatch_done, 0);
`ifdef DISPATCH_PERF_CNT_EN
    chk("t6_rst_count", o_dispatch_count, 0);
`endif
    tick();
    arst = 1'b0;
    i_user_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("t6_post_done", o_dispatch_done, 0);
      chk("t6_post_wr_en", o_arr_wr_en, 0);
      chk("t6_post_uv", o_user_data_valid, 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
